// File: rtl/imc_scheduler_pkg.sv
// Shared types and defaults for the IMC job scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package imc_sched_pkg;

    // Job sequencing states, one job in flight at a time.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESULT    = 3'd4
    } state_t;

    // Default abort limit for a job stuck waiting on the macro.
    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/imc_scheduler_if.sv
// Handshake bundle between requesters, the IMC macro and the result consumer.
// Latency: n/a (wires only).
// Backpressure: res_valid_o held until res_ready_i; req_i held until granted.
interface imc_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] gnt_o;
    logic             imc_start_o;
    logic             imc_done_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [ID_W-1:0]  res_id_o;
    logic             res_err_o;
    logic             busy_o;

    // Scheduler side
    modport master (
        input  req_i, imc_done_i, res_ready_i,
        output gnt_o, imc_start_o, res_valid_o, res_id_o, res_err_o, busy_o
    );

    // Requester / macro / consumer side
    modport slave (
        output req_i, imc_done_i, res_ready_i,
        input  gnt_o, imc_start_o, res_valid_o, res_id_o, res_err_o, busy_o
    );
endinterface

// File: rtl/imc_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; win_vld is low when no request is pending.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             win_vld,
    output logic [ID_W-1:0]  win_id
);

    int idx;

    // Scan from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/imc_scheduler.sv
// Round-robin sharing of one IMC macro: grant, start pulse, wait done, tagged result.
// Latency: req sampled in IDLE -> gnt next cycle -> start the cycle after; 5 cycles minimum per job.
// Backpressure: result held until res_ready_i; optional abort via `define IMC_SCHED_TIMEOUT_EN.
module imc_scheduler
    import imc_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = $clog2(N_REQ),
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    imc_scheduler_if.master bus
);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1) begin : g_cfg_chk
        $error("imc_scheduler: unsupported parameter set");
    end

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  owner;
    logic [N_REQ-1:0] gnt_q;
    logic             start_q;
    logic             valid_q;
    logic             err_q;
    logic             busy_q;
    logic             win_vld;
    logic [ID_W-1:0]  win_id;

`ifdef IMC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (bus.req_i),
        .ptr     (ptr),
        .win_vld (win_vld),
        .win_id  (win_id)
    );

    // Job sequencer; every output is a register so pulses are glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            ptr     <= ID_W'(N_REQ - 1);
            owner   <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef IMC_SCHED_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        owner  <= win_id;
                        gnt_q  <= N_REQ'(1) << win_id;
                        busy_q <= 1'b1;
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    gnt_q   <= '0;
                    start_q <= 1'b1;
                    state   <= ST_START;
                end
                ST_START: begin
                    start_q <= 1'b0;
                    state   <= ST_WAIT_DONE;
`ifdef IMC_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT_DONE: begin
                    // A done on the limit cycle takes precedence over the abort.
                    if (bus.imc_done_i) begin
                        valid_q <= 1'b1;
                        state   <= ST_RESULT;
                    end
`ifdef IMC_SCHED_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        state   <= ST_RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESULT: begin
                    // Rotation advances only once the result is consumed.
                    if (bus.res_ready_i) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        ptr     <= owner;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    start_q <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.imc_start_o = start_q;
    assign bus.res_valid_o = valid_q;
    assign bus.res_id_o    = owner;
    assign bus.res_err_o   = err_q;
    assign bus.busy_o      = busy_q;

endmodule
